// File: rtl/fir_out_serializer.sv
// fir_out_serializer: buffers signed FIR results in a small FIFO and emits each
// word as two bytes (low byte, then sign-extended high byte) on a valid/ready
// byte port. The upstream FIR stage cannot be stalled, so samples arriving at a
// full FIFO are dropped and recorded in a sticky overflow flag.
module fir_out_serializer #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic [AW:0]       level,
    output logic              overflow,
    input  logic              clr_ovf
);

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_t;

    localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_EMPTY = {(AW+1){1'b0}};
    localparam logic [AW:0] LVL_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       level_r;
    logic              overflow_r;
    phase_t            phase_r;
    phase_t            phase_nxt_s;

    logic [DATA_W-1:0] head_s;
    logic              not_empty_s;
    logic              full_s;
    logic              hs_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;

    // High byte of a word: bits [DATA_W-1:8] sign-extended to 8 bits.
    function automatic logic [7:0] high_byte(input logic [DATA_W-1:0] w);
        logic [15:0] ext;
        ext = {16{w[DATA_W-1]}};
        ext[DATA_W-1:0] = w;
        return ext[15:8];
    endfunction

    assign head_s      = mem_r[rd_ptr_r];
    assign not_empty_s = (level_r != LVL_EMPTY);
    assign full_s      = (level_r == LVL_FULL);
    // A byte handshake only exists when a word is held; m_ready is ignored when empty.
    assign hs_s        = not_empty_s & m_ready;
    assign pop_s       = hs_s & (phase_r == PH_HI);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_s      = s_valid & (~full_s | pop_s);
    assign drop_s      = s_valid & full_s & ~pop_s;

    assign level    = level_r;
    assign overflow = overflow_r;

    // FIFO storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_data;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= LVL_EMPTY;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                level_r <= level_r + LVL_ONE;
            end else if (pop_s && !push_s) begin
                level_r <= level_r - LVL_ONE;
            end else begin
                level_r <= level_r;
            end
            // A fresh drop takes priority over a concurrent clear.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Phase state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PH_LO;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Phase next-state: toggle on every byte handshake, otherwise hold.
    always_comb begin
        phase_nxt_s = phase_r;
        case (phase_r)
            PH_LO: begin
                if (hs_s) begin
                    phase_nxt_s = PH_HI;
                end else begin
                    phase_nxt_s = PH_LO;
                end
            end
            PH_HI: begin
                if (hs_s) begin
                    phase_nxt_s = PH_LO;
                end else begin
                    phase_nxt_s = PH_HI;
                end
            end
            default: begin
                phase_nxt_s = PH_LO;
            end
        endcase
    end

    // Byte-port outputs decoded from the head entry and the phase; all zero when empty.
    always_comb begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_last  = 1'b0;
        if (not_empty_s) begin
            m_valid = 1'b1;
            if (phase_r == PH_HI) begin
                m_data = high_byte(head_s);
                m_last = 1'b1;
            end else begin
                m_data = head_s[7:0];
                m_last = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_last  = 1'b0;
        end
    end

endmodule
